wb_ifetch: RTL and testbench
============================

Name: wb_ifetch

Overview:
- Wishbone master instruction-fetch engine. It is the initiator side for the read-only slaves on the instruction bus, such as the boot ROM.
- Issues single classic read cycles at a sequential PC and buffers returned words in a small FIFO. Presents them to the decode stage with a valid/ready handshake.
- Supports PC redirect from the execute stage and reports bus errors as fetch faults.

Parameters:
ADR_WIDTH, 64, bus address and PC width
DAT_WIDTH, 64, bus data and instruction width
RESET_PC, 64'h0000_8000_0000_0000, first fetch address after reset
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
fetch_cyc_o  out  1  Wishbone cycle
fetch_stb_o  out  1  Wishbone strobe
fetch_we_o  out  1  write enable, constant 0
fetch_sel_o  out  DAT_WIDTH/8  byte selects, constant all-ones
fetch_adr_o  out  ADR_WIDTH  address
fetch_dat_o  out  DAT_WIDTH  write data, constant 0
fetch_dat_i  in  DAT_WIDTH  read data
fetch_ack_i  in  1  slave acknowledge
fetch_err_i  in  1  slave error
insn_o  out  DAT_WIDTH  FIFO head instruction
insn_pc_o  out  ADR_WIDTH  address of insn_o
insn_valid_o  out  1  FIFO non-empty
insn_ready_i  in  1  consumer accepts head
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  ADR_WIDTH  new fetch PC; bits [2:0] ignored (forced 0)
fault_o  out  1  fetch halted on bus error
fault_pc_o  out  ADR_WIDTH  address that returned err

Behaviour:
- Reset (rst_i=0, takes effect immediately without a clock):
  - cyc/stb 0, adr_o 0, FIFO empty, insn_valid_o 0.
  - fault_o 0, fault_pc_o 0, fetch PC = RESET_PC, state IDLE, discard flag 0.
- Slot accounting: may start a request only if (FIFO count + in-flight) < FIFO_DEPTH.
- State machine:
  - IDLE:
    - If slot free and !fault_o: next cycle REQ, with cyc=stb=1 and adr_o=PC.
    - Else stay in IDLE.
  - REQ:
    - cyc, stb, adr_o held stable until ack_i or err_i is sampled high.
    - On ack: push {PC, dat_i} (unless discard flag set), PC += 8 (wraps modulo 2^ADR_WIDTH), go GAP.
    - On err (err wins over simultaneous ack): unless discarding, set fault_o=1 and fault_pc_o=adr_o, go FAULT. If discarding, go GAP and push nothing.
    - cyc/stb drop on the same edge in both cases.
  - GAP:
    - cyc=stb=0 for exactly one cycle, mandatory so registered-ack slaves return to idle.
    - Then REQ if slot free, else IDLE.
    - Peak throughput: one word per 3 cycles with a one-cycle-ack slave.
  - FAULT:
    - No bus activity. FIFO entries fetched before the fault remain deliverable.
    - Exit only via redirect.
- Output handshake:
  - insn_valid_o = FIFO non-empty; insn_o/insn_pc_o = head.
  - Pop on valid && ready.
  - Push and pop in the same cycle are legal. Overflow is impossible by slot accounting.
- Redirect (redirect_i=1 at a clock edge, any state):
  - FIFO flushed; PC = {redirect_pc_i[ADR_WIDTH-1:3],3'b0}; fault_o cleared to 0 (fault_pc_o retains value).
  - A pop requested in the same cycle is ignored; flush dominates.
  - insn_valid_o = 0 in the following cycle.
  - In REQ: the transaction is NOT aborted. Discard flag is set; the returning ack data or err is dropped. Next request uses the new PC after GAP.
  - In IDLE/GAP/FAULT: next request issues per the normal rules using the new PC.
  - Redirect arriving while the discard flag is set simply updates PC again.
- ack_i/err_i sampled outside REQ are ignored.
- Reset asserted mid-REQ: cyc/stb drop asynchronously; any in-flight data is lost.

Test Plan:
- Reset release, slave acks one cycle after stb, ready=1 -> adr_o sequence 0x800000000000, 0x...08, 0x...10; insn_pc_o matches; stb low exactly one cycle between each transaction.
- ready=0 from reset -> exactly 2 transactions complete, then cyc stays 0. Raise ready -> words for 0x...00, 0x...08 delivered in order; next adr_o 0x...10.
- Slave asserts err at adr 0x...18 -> fault_o=1, fault_pc_o=0x...18; words 0x...00–0x...10 still delivered; no cyc for 20 cycles. Then redirect 0x...00 -> fault_o=0, fetching resumes at 0x...00.
- Redirect to 0x...2b while REQ at 0x...10 pending -> that ack's data is never presented; next adr_o 0x...28; first insn_pc_o 0x...28.
- ack_i and err_i high together at adr 0x...08 -> fault_o=1, fault_pc_o=0x...08, no push.
- Assert rst_i=0 mid-REQ between clock edges -> cyc/stb low before the next edge. After release, first adr_o = RESET_PC, FIFO empty.

Source files
------------

// File: rtl/wb_ifetch.sv
// Wishbone classic-read instruction fetch engine with a small prefetch FIFO.
// Latency: request issued one cycle after a slot frees; the word is at the FIFO head the cycle after ack.
// Backpressure: insn_ready_i low fills the FIFO, after which new bus requests are held off.

// Generic synchronous FIFO with a flush that dominates both push and pop.
// Latency: a pushed word is at the head the cycle after the push.
// Backpressure: wr_vld is dropped when full; the producer must account for slots.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign rd_vld = (cnt != '0);
  assign rd_dat = mem[rd_ptr];
  assign do_wr  = wr_vld && !flush && (cnt != CW'(DEPTH));
  assign do_rd  = rd_rdy && rd_vld && !flush;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module wb_ifetch #(
  parameter int                  ADR_WIDTH  = 64,
  parameter int                  DAT_WIDTH  = 64,
  parameter logic [ADR_WIDTH-1:0] RESET_PC  = 64'h0000_8000_0000_0000,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   fetch_cyc_o,
  output logic                   fetch_stb_o,
  output logic                   fetch_we_o,
  output logic [DAT_WIDTH/8-1:0] fetch_sel_o,
  output logic [ADR_WIDTH-1:0]   fetch_adr_o,
  output logic [DAT_WIDTH-1:0]   fetch_dat_o,
  input  logic [DAT_WIDTH-1:0]   fetch_dat_i,
  input  logic                   fetch_ack_i,
  input  logic                   fetch_err_i,
  output logic [DAT_WIDTH-1:0]   insn_o,
  output logic [ADR_WIDTH-1:0]   insn_pc_o,
  output logic                   insn_valid_o,
  input  logic                   insn_ready_i,
  input  logic                   redirect_i,
  input  logic [ADR_WIDTH-1:0]   redirect_pc_i,
  output logic                   fault_o,
  output logic [ADR_WIDTH-1:0]   fault_pc_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP, FAULT} state_t;

  typedef struct packed {
    logic [ADR_WIDTH-1:0] pc;
    logic [DAT_WIDTH-1:0] dat;
  } insn_t;

  state_t               state, state_nxt;
  logic [ADR_WIDTH-1:0] pc;
  logic [ADR_WIDTH-1:0] adr;
  logic                 discard;
  logic                 fault;
  logic [ADR_WIDTH-1:0] fault_pc;
  logic [CW-1:0]        fifo_cnt;
  logic                 slot_free;
  logic                 bus_done;
  logic                 drop;
  logic                 push;
  logic                 fault_set;
  insn_t                wr_ent;
  insn_t                head;
  logic [2:0]           unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc_i[2:0];

  // Nothing is ever in flight when a new request is considered, so the FIFO count alone decides.
  assign slot_free = (fifo_cnt < CW'(FIFO_DEPTH));
  assign bus_done  = (state == REQ) && (fetch_ack_i || fetch_err_i);
  // A redirect on the completing edge drops the result just like a pending discard.
  assign drop      = discard || redirect_i;
  assign push      = (state == REQ) && fetch_ack_i && !fetch_err_i && !drop;
  assign fault_set = (state == REQ) && fetch_err_i && !drop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (slot_free && !fault) state_nxt = REQ;
      REQ: begin
        if (fetch_err_i)      state_nxt = drop ? GAP : FAULT;
        else if (fetch_ack_i) state_nxt = GAP;
      end
      GAP:     state_nxt = slot_free ? REQ : IDLE;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
    if (redirect_i && (state != REQ)) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      adr      <= '0;
      discard  <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == REQ) && (state != REQ)) adr <= pc;

      if (redirect_i)  pc <= {redirect_pc_i[ADR_WIDTH-1:3], 3'b000};
      else if (push)   pc <= pc + ADR_WIDTH'(8);

      if (bus_done)                         discard <= 1'b0;
      else if (redirect_i && state == REQ)  discard <= 1'b1;

      if (redirect_i) begin
        fault <= 1'b0;
      end else if (fault_set) begin
        fault    <= 1'b1;
        fault_pc <= adr;
      end
    end
  end

  assign wr_ent.pc  = adr;
  assign wr_ent.dat = fetch_dat_i;

  sync_fifo #(.WIDTH($bits(insn_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush  (redirect_i),
    .wr_vld (push),
    .wr_dat (wr_ent),
    .rd_rdy (insn_ready_i),
    .rd_vld (insn_valid_o),
    .rd_dat (head),
    .cnt    (fifo_cnt)
  );

  assign fetch_cyc_o = (state == REQ);
  assign fetch_stb_o = (state == REQ);
  assign fetch_we_o  = 1'b0;
  assign fetch_sel_o = '1;
  assign fetch_adr_o = adr;
  assign fetch_dat_o = '0;
  assign insn_o      = head.dat;
  assign insn_pc_o   = head.pc;
  assign fault_o     = fault;
  assign fault_pc_o  = fault_pc;
endmodule

// File: tb/tb_wb_ifetch.sv
// Bench for wb_ifetch: registered-ack Wishbone slave model plus an in-order scoreboard
// filled on each acked, non-discarded read and drained on each accepted instruction.
module tb_wb_ifetch;
  localparam logic [63:0] RPC  = 64'h0000_8000_0000_0000;
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] dat;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc, stb, we;
  logic [7:0]  sel;
  logic [63:0] adr, wdat;
  logic [63:0] rdat = '0;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic [63:0] insn, insn_pc;
  logic        insn_valid;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fault;
  logic [63:0] fault_pc;

  logic [63:0] hold_adr = NONE;
  logic [63:0] err_adr  = NONE;
  logic [63:0] both_adr = NONE;

  ent_t        sb[$];
  int          wait_cnt = 0;
  int          resp_cnt = 0;
  int          pop_cnt  = 0;
  logic [63:0] last_pop_pc = '0;
  bit          tb_discard = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk_i = ~clk_i;

  wb_ifetch dut (
    .clk_i        (clk_i),
    .rst_i        (rst_n),
    .fetch_cyc_o  (cyc),
    .fetch_stb_o  (stb),
    .fetch_we_o   (we),
    .fetch_sel_o  (sel),
    .fetch_adr_o  (adr),
    .fetch_dat_o  (wdat),
    .fetch_dat_i  (rdat),
    .fetch_ack_i  (ack),
    .fetch_err_i  (err),
    .insn_o       (insn),
    .insn_pc_o    (insn_pc),
    .insn_valid_o (insn_valid),
    .insn_ready_i (ready),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .fault_o      (fault),
    .fault_pc_o   (fault_pc)
  );

  function automatic logic [63:0] dat_of(input logic [63:0] a);
    return {a[31:0], ~a[31:0]} ^ 64'h5A5A_0F0F_3C3C_9669;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Slave responds on the second negedge of a strobe, i.e. one cycle after it registers stb.
  always @(negedge clk_i) begin
    bit resp;
    if (!rst_n) begin
      ack = 1'b0; err = 1'b0; rdat = '0;
      wait_cnt = 0; resp_cnt = 0; pop_cnt = 0;
      tb_discard = 1'b0;
      sb.delete();
    end else begin
      if (insn_valid && ready && !redirect) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          ent_t e;
          e = sb.pop_front();
          check("insn_pc", insn_pc, e.pc);
          check("insn", insn, e.dat);
        end
        pop_cnt++;
        last_pop_pc = insn_pc;
      end
      ack = 1'b0; err = 1'b0; rdat = '0;
      resp = 1'b0;
      if (cyc && stb && adr != hold_adr) begin
        if (wait_cnt >= 1) begin
          resp = 1'b1;
          wait_cnt = 0;
          resp_cnt++;
          if (adr == err_adr) err = 1'b1;
          else if (adr == both_adr) begin ack = 1'b1; err = 1'b1; rdat = dat_of(adr); end
          else begin ack = 1'b1; rdat = dat_of(adr); end
        end else begin
          wait_cnt++;
        end
      end else if (!cyc) begin
        wait_cnt = 0;
      end
      if (resp) begin
        if (ack && !err && !redirect && !tb_discard) sb.push_back('{pc: adr, dat: rdat});
        tb_discard = 1'b0;
      end
      if (redirect) begin
        sb.delete();
        if (cyc && !resp) tb_discard = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_n = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (cyc === lvl) begin ok = 1'b1; break; end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic wait_fault(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (fault === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (pop_cnt >= target) begin ok = 1'b1; break; end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic pulse_redirect(input logic [63:0] p);
    redirect_pc = p;
    redirect = 1'b1;
    @(posedge clk_i); #1;
    redirect = 1'b0;
  endtask

  initial begin
    bit          ok;
    int          low, nrise, ncyc, base;
    logic        prev;
    logic [63:0] adrs [3];
    int          gaps [3];

    // Reset values while held in reset
    #7;
    check("rst_cyc", 64'(cyc), 0);
    check("rst_stb", 64'(stb), 0);
    check("rst_adr", adr, 0);
    check("rst_valid", 64'(insn_valid), 0);
    check("rst_fault", 64'(fault), 0);
    check("rst_fault_pc", fault_pc, 0);
    check("we_const", 64'(we), 0);
    check("sel_const", 64'(sel), 64'hFF);

    // Sequential fetch with a free-running consumer
    ready = 1'b1;
    do_reset();
    low = 0; nrise = 0; prev = 1'b0;
    for (int c = 0; c < 60 && nrise < 3; c++) begin
      if (stb && !prev) begin adrs[nrise] = adr; gaps[nrise] = low; nrise++; end
      low  = stb ? 0 : low + 1;
      prev = stb;
      @(posedge clk_i); #1;
    end
    check("t1_nreq", 64'(nrise), 3);
    check("t1_adr0", adrs[0], RPC);
    check("t1_adr1", adrs[1], RPC + 64'h08);
    check("t1_adr2", adrs[2], RPC + 64'h10);
    check("t1_gap1", 64'(gaps[1]), 1);
    check("t1_gap2", 64'(gaps[2]), 1);
    wait_pops(3, 40, ok);
    check("t1_pops_to", 64'(ok), 1);

    // Consumer stalled from reset: exactly two words prefetched
    ready = 1'b0;
    do_reset();
    repeat (30) @(posedge clk_i);
    #1;
    check("t2_resp", 64'(resp_cnt), 2);
    check("t2_cyc_idle", 64'(cyc), 0);
    check("t2_valid", 64'(insn_valid), 1);
    check("t2_head_pc", insn_pc, RPC);
    ready = 1'b1;
    wait_cyc(1'b1, 20, ok);
    check("t2_cyc_to", 64'(ok), 1);
    check("t2_next_adr", adr, RPC + 64'h10);
    wait_pops(2, 20, ok);
    check("t2_pops_to", 64'(ok), 1);

    // Bus error at 0x18 halts fetch; earlier words still delivered
    err_adr = RPC + 64'h18;
    do_reset();
    wait_fault(80, ok);
    check("t3_fault_to", 64'(ok), 1);
    check("t3_fault_pc", fault_pc, RPC + 64'h18);
    ncyc = 0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (cyc) ncyc++;
    end
    check("t3_no_cyc", 64'(ncyc), 0);
    check("t3_pops", 64'(pop_cnt), 3);
    err_adr = NONE;
    pulse_redirect(RPC);
    check("t3_fault_clr", 64'(fault), 0);
    check("t3_fault_pc_keep", fault_pc, RPC + 64'h18);
    wait_cyc(1'b1, 20, ok);
    check("t3_cyc_to", 64'(ok), 1);
    check("t3_restart_adr", adr, RPC);
    wait_pops(4, 40, ok);
    check("t3_pop_to", 64'(ok), 1);
    check("t3_first_pc", last_pop_pc, RPC);

    // Redirect while the read at 0x10 is outstanding
    hold_adr = RPC + 64'h10;
    do_reset();
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (cyc && adr == hold_adr) begin ok = 1'b1; break; end
      @(posedge clk_i); #1;
    end
    check("t4_hold_to", 64'(ok), 1);
    repeat (2) @(posedge clk_i);
    #1 base = pop_cnt;
    pulse_redirect(RPC + 64'h2b);
    check("t4_valid_flush", 64'(insn_valid), 0);
    check("t4_still_req", 64'(cyc), 1);
    hold_adr = NONE;
    wait_cyc(1'b0, 20, ok);
    check("t4_end_to", 64'(ok), 1);
    wait_cyc(1'b1, 20, ok);
    check("t4_cyc_to", 64'(ok), 1);
    check("t4_next_adr", adr, RPC + 64'h28);
    wait_pops(base + 1, 40, ok);
    check("t4_pop_to", 64'(ok), 1);
    check("t4_first_pc", last_pop_pc, RPC + 64'h28);

    // ack and err together: error wins, nothing pushed
    both_adr = RPC + 64'h08;
    do_reset();
    wait_fault(80, ok);
    check("t5_fault_to", 64'(ok), 1);
    check("t5_fault_pc", fault_pc, RPC + 64'h08);
    repeat (5) @(posedge clk_i);
    #1;
    check("t5_pops", 64'(pop_cnt), 1);
    check("t5_valid", 64'(insn_valid), 0);
    both_adr = NONE;

    // Asynchronous reset in the middle of a request
    hold_adr = RPC;
    do_reset();
    wait_cyc(1'b1, 20, ok);
    check("t6_cyc_to", 64'(ok), 1);
    @(posedge clk_i); #3;
    rst_n = 1'b0;
    #1;
    check("t6_cyc_async", 64'(cyc), 0);
    check("t6_stb_async", 64'(stb), 0);
    hold_adr = NONE;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    check("t6_valid", 64'(insn_valid), 0);
    wait_cyc(1'b1, 20, ok);
    check("t6_cyc2_to", 64'(ok), 1);
    check("t6_adr", adr, RPC);
    wait_pops(1, 40, ok);
    check("t6_pop_to", 64'(ok), 1);
    check("t6_first_pc", last_pop_pc, RPC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
